// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program-counter controller for cpu_32.
// Chooses each cycle between sequential PC+4, conditional branch, J-type jump
// and register jump. Optional macro PC_DELAY_SLOT_EN selects MIPS delay-slot
// sequencing (SEQ/SLOT FSM); without it a taken request redirects immediately
// and raises flush so the decoder can squash the instruction at pc.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_valid,
  input  logic [25:0] j_target,
  input  logic        jr_valid,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        flush,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;

  logic [31:0] br_tgt, j_tgt, jr_tgt, req_tgt;
  logic        req_taken;

`ifdef PC_DELAY_SLOT_EN
  typedef enum logic {SEQ = 1'b0, SLOT = 1'b1} state_e;
  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
`endif

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign redirect     = redirect_q;
  assign misalign_err = misalign_q;

  // Candidate targets and priority select: jr > j > taken branch.
  always_comb begin
    br_tgt    = pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    j_tgt     = {pc_plus4[31:28], j_target, 2'b00};
    jr_tgt    = {jr_addr[31:2], 2'b00};
    req_taken = jr_valid | j_valid | (br_valid & br_taken);
    if (jr_valid)     req_tgt = jr_tgt;
    else if (j_valid) req_tgt = j_tgt;
    else              req_tgt = br_tgt;
  end

`ifdef PC_DELAY_SLOT_EN
  // Next-state logic: SEQ accepts requests, SLOT fetches the delay slot then jumps.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    target_d   = target_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    flush      = 1'b0;
    if (!stall) begin
      case (state_q)
        SEQ: begin
          pc_d = pc_plus4;
          if (req_taken) begin
            target_d = req_tgt;
            state_d  = SLOT;
            if (jr_valid && (jr_addr[1:0] != 2'b00)) misalign_d = 1'b1;
          end
        end
        SLOT: begin
          pc_d       = target_q;
          redirect_d = 1'b1;
          state_d    = SEQ;
        end
        default: state_d = SEQ;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      state_q    <= SEQ;
      target_q   <= 32'h0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end
`else
  // Next-state logic: a taken request loads pc directly and squashes the current instruction.
  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    flush      = 1'b0;
    if (!stall) begin
      if (req_taken) begin
        pc_d       = req_tgt;
        redirect_d = 1'b1;
        flush      = 1'b1;
        if (jr_valid && (jr_addr[1:0] != 2'b00)) misalign_d = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// behavioural model. Follows the PC_DELAY_SLOT_EN macro like the design.
module tb_pc_sequencer;
  localparam logic [31:0] RP = 32'h0000_0000;
`ifdef PC_DELAY_SLOT_EN
  localparam bit SLOT_BUILD = 1'b1;
`else
  localparam bit SLOT_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, br_valid, br_taken, j_valid, jr_valid;
  logic [15:0] br_imm;
  logic [25:0] j_target;
  logic [31:0] jr_addr;
  logic [31:0] pc, pc_plus4;
  logic        redirect, flush, misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_pc, m_tgt;
  bit          m_pending, m_redir, m_mis;

  pc_sequencer #(.RESET_PC(RP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
    .br_imm(br_imm), .j_valid(j_valid), .j_target(j_target), .jr_valid(jr_valid),
    .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .flush(flush),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic bit req_taken();
    return jr_valid || j_valid || (br_valid && br_taken);
  endfunction

  function automatic logic [31:0] req_target();
    logic [31:0] nxt;
    int          off;
    nxt = m_pc + 32'd4;
    if (jr_valid) return jr_addr & 32'hFFFF_FFFC;
    if (j_valid)  return (nxt & 32'hF000_0000) | (32'(j_target) * 4);
    off = int'($signed(br_imm)) * 4;
    return nxt + 32'(off);
  endfunction

  function automatic bit exp_flush();
    return !SLOT_BUILD && !stall && req_taken();
  endfunction

  // Advance model using current inputs, then clock the DUT and settle.
  task automatic step();
    logic [31:0] t;
    if (!rst_n) begin
      m_pc = RP; m_tgt = 0; m_pending = 0; m_redir = 0; m_mis = 0;
    end else if (stall) begin
      m_redir = 0;
    end else if (m_pending) begin
      m_pc = m_tgt; m_pending = 0; m_redir = 1;
    end else if (req_taken()) begin
      t = req_target();
      if (jr_valid && jr_addr[1:0] != 2'b00) m_mis = 1;
      if (SLOT_BUILD) begin
        m_tgt = t; m_pending = 1; m_pc = m_pc + 32'd4; m_redir = 0;
      end else begin
        m_pc = t; m_redir = 1;
      end
    end else begin
      m_pc = m_pc + 32'd4; m_redir = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_valid = 0; br_taken = 0; br_imm = 0;
    j_valid = 0; j_target = 0; jr_valid = 0; jr_addr = 0;
  endtask

  // Move pc to an aligned address through a register jump.
  task automatic goto(input logic [31:0] a);
    idle_inputs();
    jr_valid = 1; jr_addr = a;
    step();
    idle_inputs();
    if (SLOT_BUILD) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; stall = 1; br_valid = 1; br_taken = 1; br_imm = 16'h0040;
    step(); step();
    n_checks++; if (pc !== RP) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, RP); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    rst_n = 1; idle_inputs();
  endtask

  task automatic test_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFFC; exp[1] = 32'h0; exp[2] = 32'h4;
    goto(32'hFFFF_FFF8);
    n_checks++; if (pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_start got=%h exp=fffffff8", pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc !== exp[i]) begin n_fail++; $display("FAIL wrap_seq%0d got=%h exp=%h", i, pc, exp[i]); end
      if (i == 0) begin
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4 got=%h exp=0", pc_plus4); end
      end
    end
  endtask

  task automatic test_neg_branch();
    goto(32'h100);
    br_valid = 1; br_taken = 1; br_imm = 16'hFFFE;
    #1;
`ifdef PC_DELAY_SLOT_EN
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL negbr_flush got=%b exp=0", flush); end
    step(); idle_inputs();
    n_checks++; if (pc !== 32'h104) begin n_fail++; $display("FAIL negbr_slot got=%h exp=104", pc); end
    step();
`else
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL negbr_flush got=%b exp=1", flush); end
    step(); idle_inputs();
`endif
    n_checks++; if (pc !== 32'hFC) begin n_fail++; $display("FAIL negbr_pc got=%h exp=fc", pc); end
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL negbr_redirect got=%b exp=1", redirect); end
  endtask

  task automatic test_priority();
    goto(32'h4000_0010);
    jr_valid = 1; jr_addr = 32'h200; j_valid = 1; j_target = 26'h1;
    br_valid = 1; br_taken = 1; br_imm = 16'h0100;
    step(); idle_inputs();
    if (SLOT_BUILD) step();
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL prio_jr got=%h exp=200", pc); end
    // j alone from the same spot: region bits from pc_plus4
    goto(32'h4000_0010);
    j_valid = 1; j_target = 26'h1; br_valid = 1; br_taken = 1;
    step(); idle_inputs();
    if (SLOT_BUILD) step();
    n_checks++; if (pc !== 32'h4000_0004) begin n_fail++; $display("FAIL prio_j got=%h exp=40000004", pc); end
  endtask

  task automatic test_stall_slot();
    goto(32'h200);
    br_valid = 1; br_taken = 1; br_imm = 16'h0010;
    step(); idle_inputs();
`ifdef PC_DELAY_SLOT_EN
    for (int i = 0; i < 3; i++) begin
      stall = 1; jr_valid = 1; jr_addr = 32'h0000_0800; j_valid = 1; j_target = 26'h55;
      step();
      n_checks++; if (pc !== 32'h204) begin n_fail++; $display("FAIL slot_stall%0d got=%h exp=204", i, pc); end
      n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL slot_stall_redir%0d got=%b exp=0", i, redirect); end
    end
    stall = 0;
    step(); idle_inputs();
    n_checks++; if (pc !== 32'h244) begin n_fail++; $display("FAIL slot_release got=%h exp=244", pc); end
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL slot_release_redir got=%b exp=1", redirect); end
`else
    n_checks++; if (pc !== 32'h244) begin n_fail++; $display("FAIL nsl_branch got=%h exp=244", pc); end
    for (int i = 0; i < 3; i++) begin
      stall = 1; jr_valid = 1; jr_addr = 32'h0000_0800;
      #1;
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL nsl_stall_flush%0d got=%b exp=0", i, flush); end
      step();
      n_checks++; if (pc !== 32'h244) begin n_fail++; $display("FAIL nsl_stall%0d got=%h exp=244", i, pc); end
    end
    idle_inputs();
`endif
    step();
    n_checks++; if (pc !== 32'h248) begin n_fail++; $display("FAIL stall_after got=%h exp=248", pc); end
  endtask

  task automatic test_misalign();
    goto(32'h40);
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_pre got=%b exp=0", misalign_err); end
    jr_valid = 1; jr_addr = 32'h0000_0303;
    step(); idle_inputs();
    if (SLOT_BUILD) step();
    n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL mis_pc got=%h exp=300", pc); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_set got=%b exp=1", misalign_err); end
    step(); step();
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got=%b exp=1", misalign_err); end
    rst_n = 0; step(); rst_n = 1;
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", misalign_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      br_valid = $urandom_range(0, 1);
      br_taken = $urandom_range(0, 1);
      br_imm   = 16'($urandom);
      j_valid  = ($urandom_range(0, 5) == 0);
      j_target = 26'($urandom);
      jr_valid = ($urandom_range(0, 7) == 0);
      jr_addr  = $urandom;
      #1;
      n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
      n_checks++; if (pc_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_plus4[%0d] got=%h exp=%h", i, pc_plus4, m_pc + 32'd4); end
      n_checks++; if (redirect !== m_redir) begin n_fail++; $display("FAIL rnd_redirect[%0d] got=%b exp=%b", i, redirect, m_redir); end
      n_checks++; if (misalign_err !== m_mis) begin n_fail++; $display("FAIL rnd_misalign[%0d] got=%b exp=%b", i, misalign_err, m_mis); end
      n_checks++; if (flush !== exp_flush()) begin n_fail++; $display("FAIL rnd_flush[%0d] got=%b exp=%b", i, flush, exp_flush()); end
      step();
    end
    rst_n = 1; idle_inputs();
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_wrap();
    test_neg_branch();
    test_priority();
    test_stall_slot();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
